// File: rtl/whack_sequencer.sv
// Game-flow controller for whack-a-mole: countdown, timed play window with
// mole spawning/aging, hit scoring, and a game-over hold.
module whack_sequencer #(
   parameter int COUNTDOWN_S = 5,
   parameter int PLAY_S      = 30,
   parameter int MOLE_TICKS  = 2,
   parameter int MAX_SCORE   = 9999
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        tick_i,
   input  logic        start_i,
   input  logic [2:0]  rnd_i,
   input  logic [4:0]  whack_i,
   output logic [4:0]  led,
   output logic [15:0] score,
   output logic [7:0]  count_o,
   output logic [1:0]  state_o,
   output logic        playing_o
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      COUNTDOWN = 2'b01,
      PLAY      = 2'b10,
      OVER      = 2'b11
   } state_t;

   localparam logic [7:0]  CD_LOAD   = 8'(COUNTDOWN_S);
   localparam logic [7:0]  PLAY_LOAD = 8'(PLAY_S);
   localparam logic [7:0]  MOLE_LIFE = 8'(MOLE_TICKS);
   localparam logic [15:0] SCORE_CAP = 16'(MAX_SCORE);

   state_t      state_q;
   logic [4:0]  led_q;
   logic [15:0] score_q;
   logic [7:0]  count_q;
   logic        playing_q;
   logic [2:0]  prevIdx_q;
   logic [7:0]  moleAge_q;

   logic        startPrev_q;
   logic        startRise_q;
   logic [4:0]  whackPrev_q;
   logic [4:0]  whackRise_q;

   logic [2:0]  foldIdx;
   logic [2:0]  spawnIdx;
   logic [4:0]  spawnLed;
   logic        hitNow;
   logic        finalTick;
   logic        moleExpired;

   // Button rises are registered, so a press takes one edge to be seen and
   // a second edge to act on the game state.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         startPrev_q <= 1'b0;
         startRise_q <= 1'b0;
         whackPrev_q <= '0;
         whackRise_q <= '0;
      end else begin
         startPrev_q <= start_i;
         startRise_q <= start_i & ~startPrev_q;
         whackPrev_q <= whack_i;
         whackRise_q <= whack_i & ~whackPrev_q;
      end
   end

   // Fold the 3-bit random value onto five moles and never repeat the last one.
   always_comb begin
      foldIdx  = (rnd_i < 3'd5) ? rnd_i : rnd_i - 3'd5;
      spawnIdx = foldIdx;
      if (foldIdx == prevIdx_q) begin
         spawnIdx = (foldIdx == 3'd4) ? 3'd0 : foldIdx + 3'd1;
      end
      spawnLed    = 5'b00001 << spawnIdx;
      hitNow      = |(whackRise_q & led_q);
      finalTick   = tick_i && (count_q == 8'd1);
      moleExpired = (moleAge_q + 8'd1) >= MOLE_LIFE;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         led_q     <= '0;
         score_q   <= '0;
         count_q   <= '0;
         playing_q <= 1'b0;
         prevIdx_q <= '0;
         moleAge_q <= '0;
      end else begin
         case (state_q)
            IDLE, OVER: begin
               if (startRise_q) begin
                  state_q <= COUNTDOWN;
                  count_q <= CD_LOAD;
                  score_q <= '0;
               end
            end
            COUNTDOWN: begin
               if (tick_i) begin
                  if (count_q == 8'd1) begin
                     state_q   <= PLAY;
                     count_q   <= PLAY_LOAD;
                     playing_q <= 1'b1;
                     led_q     <= spawnLed;
                     prevIdx_q <= spawnIdx;
                     moleAge_q <= '0;
                  end else begin
                     count_q <= count_q - 8'd1;
                  end
               end
            end
            PLAY: begin
               // The closing tick wins over any hit or aging in the same cycle.
               if (finalTick) begin
                  state_q   <= OVER;
                  led_q     <= '0;
                  count_q   <= '0;
                  playing_q <= 1'b0;
               end else begin
                  if (tick_i) begin
                     count_q <= count_q - 8'd1;
                  end
                  if (hitNow) begin
                     if (score_q < SCORE_CAP) begin
                        score_q <= score_q + 16'd1;
                     end
                     if (tick_i) begin
                        led_q     <= spawnLed;
                        prevIdx_q <= spawnIdx;
                        moleAge_q <= '0;
                     end else begin
                        led_q <= '0;
                     end
                  end else if (tick_i) begin
                     if ((led_q == 5'd0) || moleExpired) begin
                        led_q     <= spawnLed;
                        prevIdx_q <= spawnIdx;
                        moleAge_q <= '0;
                     end else begin
                        moleAge_q <= moleAge_q + 8'd1;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign led       = led_q;
   assign score     = score_q;
   assign count_o   = count_q;
   assign state_o   = state_q;
   assign playing_o = playing_q;

endmodule

// File: tb/tb_whack_sequencer.sv
// Randomized scoreboard bench for whack_sequencer: a game-level reference model
// predicts every cycle's outputs and a monitor compares them against the DUT.
module tb_whack_sequencer;

   localparam int CD = 5;
   localparam int PL = 30;
   localparam int MT = 2;
   localparam int MS = 12;
   localparam int TP = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        tick;
   logic        start;
   logic [2:0]  rnd;
   logic [4:0]  whack;
   logic [4:0]  led;
   logic [15:0] score;
   logic [7:0]  count;
   logic [1:0]  state;
   logic        playing;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   whack_sequencer #(
      .COUNTDOWN_S(CD),
      .PLAY_S(PL),
      .MOLE_TICKS(MT),
      .MAX_SCORE(MS)
   ) dut (
      .clk_i(clk),
      .reset_i(reset),
      .tick_i(tick),
      .start_i(start),
      .rnd_i(rnd),
      .whack_i(whack),
      .led(led),
      .score(score),
      .count_o(count),
      .state_o(state),
      .playing_o(playing)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  led;
      logic [15:0] score;
      logic [7:0]  count;
      logic [1:0]  state;
      logic        playing;
   } exp_t;

   exp_t expQ[$];

   // Reference game state: phase 0..3, seconds left, score, lit mole (-1 none).
   int         mState, mCount, mScore, mMole, mPrev, mAge;
   logic       mPendStart, mLastStart;
   logic [4:0] mPendWhack, mLastWhack;

   function automatic logic [4:0] maskOf(input int idx);
      logic [4:0] one;
      one = 5'b00001;
      return (idx < 0) ? 5'b00000 : (one << idx);
   endfunction

   function void spawnMole();
      int idx;
      idx = int'(rnd) % 5;
      if (idx == mPrev) idx = (idx + 1) % 5;
      mMole = idx;
      mPrev = idx;
      mAge  = 0;
   endfunction

   // The model advances once per clock edge from the inputs held during the cycle.
   always @(posedge clk) begin
      logic hit;
      exp_t e;
      if (reset) begin
         mState = 0; mCount = 0; mScore = 0; mMole = -1; mPrev = 0; mAge = 0;
         mPendStart = 1'b0; mLastStart = 1'b0;
         mPendWhack = 5'b0; mLastWhack = 5'b0;
      end else begin
         hit = (mState == 2) && (|(mPendWhack & maskOf(mMole)));
         case (mState)
            0, 3: if (mPendStart) begin
               mState = 1; mCount = CD; mScore = 0;
            end
            1: if (tick) begin
               if (mCount == 1) begin
                  mState = 2; mCount = PL; spawnMole();
               end else begin
                  mCount = mCount - 1;
               end
            end
            default: begin
               if (tick && mCount == 1) begin
                  mState = 3; mCount = 0; mMole = -1;
               end else begin
                  if (tick) mCount = mCount - 1;
                  if (hit) begin
                     mScore = (mScore + 1 > MS) ? MS : mScore + 1;
                     if (tick) spawnMole();
                     else mMole = -1;
                  end else if (tick) begin
                     if (mMole < 0 || mAge + 1 >= MT) spawnMole();
                     else mAge = mAge + 1;
                  end
               end
            end
         endcase
         mPendStart = start & ~mLastStart;
         mPendWhack = whack & ~mLastWhack;
         mLastStart = start;
         mLastWhack = whack;
      end
      e.led     = maskOf(mMole);
      e.score   = 16'(mScore);
      e.count   = 8'(mCount);
      e.state   = 2'(mState);
      e.playing = (mState == 2);
      expQ.push_back(e);
   end

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: every cycle the DUT presents a fresh registered output set.
   always @(negedge clk) begin
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("led", {11'b0, led}, {11'b0, e.led});
         checkOutput("score", score, e.score);
         checkOutput("count", {8'b0, count}, {8'b0, e.count});
         checkOutput("state", {14'b0, state}, {14'b0, e.state});
         checkOutput("playing", {15'b0, playing}, {15'b0, e.playing});
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
      cyc++;
      tick = (cyc % TP == 0);
   endtask

   // Modes: 0 idle player, 1 random player, 2 scripted presses, 3 hit every mole.
   task automatic applyStimulus(input int mode, input int resetAtScore);
      int  action;
      int  r;
      int  scoreBefore;
      bit  finalPress;
      bit  done;
      action = 0;
      scoreBefore = -1;
      finalPress = 0;
      done = 0;
      whack = 5'b0;
      rnd = 3'(mode == 2 ? 6 : $urandom_range(0, 7));
      nextCycle(); start = 1'b1;
      nextCycle(); start = 1'b1;
      nextCycle(); start = 1'b0;
      checkOutput("start_state", {14'b0, state}, 16'd1);
      checkOutput("start_score", score, 16'd0);
      checkOutput("start_count", {8'b0, count}, 16'(CD));
      for (int n = 0; n < 1000 && !done; n++) begin
         nextCycle();
         if (mode == 2) rnd = (mState == 2) ? 3'd1 : 3'd6;
         else rnd = 3'($urandom_range(0, 7));
         if (mode == 2 && mState == 2 && n > 0 && action == 0 && cyc % TP == 1)
            checkOutput("first_spawn", {11'b0, led}, 16'h0002);
         if (mState == 3) begin
            whack = 5'b0;
            checkOutput("over_led", {11'b0, led}, 16'd0);
            checkOutput("over_count", {8'b0, count}, 16'd0);
            if (mode == 2) checkOutput("scripted_score", score, 16'd4);
            if (finalPress) checkOutput("final_tick_score", score, 16'(scoreBefore));
            done = 1;
         end else if (resetAtScore > 0 && mState == 2 && mScore == resetAtScore) begin
            checkOutput("pre_reset_score", score, 16'(resetAtScore));
            whack = 5'b0;
            reset = 1'b1;
            nextCycle();
            reset = 1'b0;
            checkOutput("reset_state", {14'b0, state}, 16'd0);
            checkOutput("reset_led", {11'b0, led}, 16'd0);
            checkOutput("reset_score", score, 16'd0);
            checkOutput("reset_count", {8'b0, count}, 16'd0);
            done = 1;
         end else if (mState != 2) begin
            whack = 5'b0;
         end else if ((mode == 1 || mode == 3) && mCount <= 2) begin
            whack = 5'b0;
            if (mCount == 1 && (cyc + 1) % TP == 0 && mMole >= 0) begin
               whack = maskOf(mMole);
               scoreBefore = mScore;
               finalPress = 1;
            end
         end else if (mode == 2) begin
            whack = 5'b0;
            if (cyc % TP == 2 && action < 6) begin
               if (action < 3) whack = maskOf(mMole);
               else if (action < 5) whack = maskOf((mMole + 1) % 5);
               else whack = 5'b11111;
               action++;
            end
         end else if (mode == 1) begin
            start = ($urandom_range(0, 15) == 0);
            if (whack != 5'b0) whack = 5'b0;
            else begin
               r = $urandom_range(0, 5);
               if (r < 2) whack = maskOf(mMole);
               else if (r == 2) whack = 5'($urandom_range(1, 31));
            end
         end else if (mode == 3) begin
            whack = (whack != 5'b0) ? 5'b0 : maskOf(mMole);
         end
      end
      start = 1'b0;
      if (!done) begin
         errors++;
         $display("[TB] FAIL game_timeout actual=running required=over mode=%0d", mode);
      end
   endtask

   initial begin
      reset = 1'b1;
      tick  = 1'b0;
      start = 1'b0;
      rnd   = 3'd0;
      whack = 5'b0;
      repeat (3) nextCycle();
      reset = 1'b0;
      checkOutput("init_state", {14'b0, state}, 16'd0);
      checkOutput("init_led", {11'b0, led}, 16'd0);
      checkOutput("init_score", score, 16'd0);
      checkOutput("init_count", {8'b0, count}, 16'd0);
      checkOutput("init_playing", {15'b0, playing}, 16'd0);
      applyStimulus(2, 0);
      applyStimulus(0, 0);
      applyStimulus(3, 7);
      applyStimulus(3, 0);
      for (int g = 0; g < 3; g++) applyStimulus(1, 0);
      repeat (4) nextCycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/whack_sequencer.md
# whack_sequencer

Game-flow controller for the whack-a-mole top level. Sequences each round through a 5 s countdown, a 30 s play window and a game-over hold. During play it owns the mole LEDs, spawns moles from an external random source, detects hits on the debounced buttons and maintains the score. Its score and seconds-remaining outputs feed the display controller; it runs entirely in the `clk_i` domain, and slow time arrives as a 1 Hz enable pulse.

## Interface
- `COUNTDOWN_S`, default 5: countdown length in seconds.
- `PLAY_S`, default 30: play window length in seconds.
- `MOLE_TICKS`, default 2: seconds an unhit mole stays lit (≥1).
- `MAX_SCORE`, default 9999: score saturation value.
- `clk_i`  in  1  system clock; the only clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `tick_i`  in  1  1 Hz enable, high exactly one `clk_i` cycle per second.
- `start_i`  in  1  debounced start button (level).
- `rnd_i`  in  3  free-running random value, sampled only at spawn.
- `whack_i`  in  5  debounced mole buttons (levels).
- `led`  out  5  lit mole, one-hot or zero.
- `score`  out  16  hits this round, binary.
- `count_o`  out  8  seconds remaining in the current phase.
- `state_o`  out  2  00 IDLE, 01 COUNTDOWN, 10 PLAY, 11 OVER.
- `playing_o`  out  1  high only in PLAY.

## Operation
- Reset values: state IDLE, `led`=0, `score`=0, `count_o`=0, `playing_o`=0, previous-mole index=0, mole age=0, edge registers=0.
- Rising edges of `start_i` and of each `whack_i` bit come from one-cycle-delayed copies of the inputs.
- IDLE: on a `start_i` rise, go to COUNTDOWN, set `count_o`=`COUNTDOWN_S` and clear `score`.
- COUNTDOWN: on each `tick_i`, decrement `count_o`. A tick at `count_o`=1 moves to PLAY, loads `PLAY_S` and spawns a mole in the same cycle.
- PLAY: on each `tick_i`, decrement `count_o`. A tick at `count_o`=1 moves to OVER, forces `led`=0 and leaves `count_o`=0.
- OVER: `score` holds. A `start_i` rise restarts exactly as it does from IDLE.
- Spawn: idx = `rnd_i` if `rnd_i`<5, otherwise `rnd_i`−5. If idx equals the previous index, use (idx+1) mod 5. Then `led`=1<<idx, record idx, set age=0.
- Mole aging: on a PLAY `tick_i` with a mole lit, age increments. When age reaches `MOLE_TICKS`, respawn instead of incrementing. Every PLAY tick with `led`=0 spawns.
- Hit: a `whack_i[k]` rise while `led[k]`=1 in PLAY sets `score`=min(`score`+1, `MAX_SCORE`) and clears `led` next cycle. The next tick spawns.
- Rises on unlit buttons do nothing. Rises outside PLAY do nothing. If several bits rise in the same cycle, at most one hit is scored, and only if the lit bit is among them.
- Priority in a single cycle: phase-end tick beats everything. A hit on the final tick is not scored. Otherwise a hit is evaluated before aging; a hit and a tick together score the hit and spawn a new mole in that cycle.
- A `start_i` rise during COUNTDOWN or PLAY is ignored.

## Timing
- All outputs are registered and change one `clk_i` edge after the qualifying input cycle.
- A hit rise sampled in cycle n updates `score` and `led` at edge n+2 (n+1 edge detect, n+2 update).
- Spawn on the PLAY entry edge: `led` is nonzero in the first cycle that `state_o`=10.
- `reset_i` sampled high at any edge restores all reset values, including mid-PLAY, with no residual mole or score.
- `tick_i` is assumed to be a single cycle. A held `tick_i` counts once per cycle, so the bench must not hold it.

## Test plan
- Reset mid-PLAY with `score`=7 → next cycle: `state_o`=00, `led`=0, `score`=0, `count_o`=0.
- `start_i` rise, then 5 ticks → `count_o` steps 5,4,3,2,1. On the 5th tick `state_o`=10, `count_o`=30, and `led` is one-hot.
- `rnd_i`=6 at spawn with previous idx 0 → `led`=5'b00010. `rnd_i`=1 next spawn → idx collides, so `led`=5'b00100.
- Hit the lit button 3 times, press unlit buttons twice, press all 5 buttons once (lit included) → `score`=4.
- No presses, `MOLE_TICKS`=2 → the mole changes every 2nd tick. After 30 PLAY ticks: `state_o`=11, `led`=0, `count_o`=0, `score` held.
- Lit-button hit in the same cycle as the final PLAY tick → `score` unchanged and `state_o`=11. A `start_i` rise in OVER → COUNTDOWN with `score`=0.
